tag_free_list: RTL and testbench

//  Multi-port circular free list of physical register tags for the rename stage. Hands out up to

---
 rtl/tag_free_list_pkg.sv | 21 ++
 rtl/tag_free_list_compactor.sv | 27 ++
 rtl/tag_free_list.sv | 148 ++++++++++++++
 tb/tb_tag_free_list.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/tag_free_list_pkg.sv
// Shared defaults and width helpers for the rename-stage physical tag free list.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package tag_free_list_pkg;

   localparam int FL_NUM_TAGS      = 128;
   localparam int FL_RESERVED_TAGS = 32;
   localparam int FL_ALLOC_PORTS   = 2;
   localparam int FL_FREE_PORTS    = 2;

   // Bits needed to name one physical tag.
   function automatic int tag_w(input int num_tags);
      return $clog2(num_tags);
   endfunction

   // Occupancy counter width: one extra bit so a completely full list (NUM_TAGS) is representable.
   function automatic int cnt_w(input int num_tags);
      return $clog2(num_tags) + 1;
   endfunction

endpackage

// File: rtl/tag_free_list_compactor.sv
// Free-port compactor: squeezes the valid returned tags into ascending slots and counts them.
// Latency: purely combinational.
// Backpressure: none; every valid tag is presented, the parent decides whether to accept.
module tag_free_list_compactor #(
   parameter int FREE_PORTS = 2,
   parameter int TW         = 7,
   parameter int FCW        = 2
) (
   input  logic [FREE_PORTS-1:0]    free_valid,
   input  logic [FREE_PORTS*TW-1:0] free_tag,
   output logic [FREE_PORTS*TW-1:0] packed_tag,
   output logic [FCW-1:0]           packed_cnt
);

   // Walk ports lowest first; each valid tag lands in the next unused packed slot.
   always_comb begin
      packed_tag = '0;
      packed_cnt = '0;
      for (int i = 0; i < FREE_PORTS; i++) begin
         if (free_valid[i]) begin
            packed_tag[int'(packed_cnt)*TW +: TW] = free_tag[i*TW +: TW];
            packed_cnt = packed_cnt + FCW'(1);
         end
      end
   end

endmodule

// File: rtl/tag_free_list.sv
// Circular free list of physical register tags: ALLOC_PORTS tags out, FREE_PORTS tags back per cycle.
// Latency: allocation tags are combinational from the read pointer; frees become allocatable next cycle.
// Backpressure: alloc_ready drops when the request exceeds occupancy (all-or-nothing); overflowing frees are dropped and flagged.
// Optional checkpoint/restore of the read side is built when FREE_LIST_CKPT_EN is defined.
module tag_free_list
   import tag_free_list_pkg::*;
#(
   parameter int NUM_TAGS      = FL_NUM_TAGS,
   parameter int RESERVED_TAGS = FL_RESERVED_TAGS,
   parameter int ALLOC_PORTS   = FL_ALLOC_PORTS,
   parameter int FREE_PORTS    = FL_FREE_PORTS
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [$clog2(ALLOC_PORTS+1)-1:0]      alloc_num,
   output logic                                  alloc_ready,
   output logic [ALLOC_PORTS*tag_w(NUM_TAGS)-1:0] alloc_tag,
   input  logic [FREE_PORTS-1:0]                 free_valid,
   input  logic [FREE_PORTS*tag_w(NUM_TAGS)-1:0] free_tag,
   output logic [cnt_w(NUM_TAGS)-1:0]            num_items,
   output logic [cnt_w(NUM_TAGS)-1:0]            freespace,
   output logic                                  overflow_err
`ifdef FREE_LIST_CKPT_EN
   ,
   input  logic                                  ckpt_save,
   input  logic                                  ckpt_restore
`endif
);

   localparam int TW   = tag_w(NUM_TAGS);
   localparam int CW   = cnt_w(NUM_TAGS);
   localparam int XW   = CW + 1;
   localparam int FCW  = $clog2(FREE_PORTS + 1);
   localparam int AW   = $clog2(ALLOC_PORTS + 1);
   localparam int INIT = NUM_TAGS - RESERVED_TAGS;

   logic [TW-1:0] mem_q [NUM_TAGS];
   logic [TW-1:0] mem_d [NUM_TAGS];
   logic [TW-1:0] rd_ptr_q, rd_ptr_d;
   logic [TW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;

   logic [FREE_PORTS*TW-1:0] packed_tag;
   logic [FCW-1:0]           packed_cnt;
   logic [AW-1:0]            alloc_k;
   logic [XW-1:0]            base_cnt;
   logic [XW-1:0]            next_cnt;
   logic                     restore_w;
   logic [CW-1:0]            restore_add;

`ifdef FREE_LIST_CKPT_EN
   logic [TW-1:0] ckpt_ptr_q, ckpt_ptr_d;
   logic [CW-1:0] since_q, since_d;
   assign restore_w   = ckpt_restore;
   assign restore_add = ckpt_restore ? since_q : '0;
`else
   assign restore_w   = 1'b0;
   assign restore_add = '0;
`endif

   tag_free_list_compactor #(
      .FREE_PORTS (FREE_PORTS),
      .TW         (TW),
      .FCW        (FCW)
   ) u_compactor (
      .free_valid (free_valid),
      .free_tag   (free_tag),
      .packed_tag (packed_tag),
      .packed_cnt (packed_cnt)
   );

   assign num_items    = count_q;
   assign freespace    = CW'(NUM_TAGS) - count_q;
   assign overflow_err = ovf_q;

   // Read ports and grant: tags come straight from the head; a restore cycle never grants.
   always_comb begin
      alloc_tag   = '0;
      alloc_ready = !restore_w && (CW'(alloc_num) <= count_q);
      alloc_k     = alloc_ready ? alloc_num : '0;
      for (int i = 0; i < ALLOC_PORTS; i++) begin
         alloc_tag[i*TW +: TW] = mem_q[rd_ptr_q + TW'(i)];
      end
   end

   // Next state: pop the head, reinstate restored tags, then append frees unless they would overflow.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      ovf_d    = ovf_q;
      rd_ptr_d = rd_ptr_q + TW'(alloc_k);
      base_cnt = XW'(count_q) + XW'(restore_add) - XW'(alloc_k);
      next_cnt = base_cnt + XW'(packed_cnt);
      count_d  = CW'(base_cnt);
      if (next_cnt <= XW'(NUM_TAGS)) begin
         count_d  = CW'(next_cnt);
         wr_ptr_d = wr_ptr_q + TW'(packed_cnt);
         for (int j = 0; j < FREE_PORTS; j++) begin
            if (FCW'(j) < packed_cnt) begin
               mem_d[wr_ptr_q + TW'(j)] = packed_tag[j*TW +: TW];
            end
         end
      end else begin
         // Whole free batch is dropped; the error stays up until reset.
         ovf_d = 1'b1;
      end
`ifdef FREE_LIST_CKPT_EN
      ckpt_ptr_d = ckpt_ptr_q;
      since_d    = since_q + CW'(alloc_k);
      if (ckpt_restore) begin
         rd_ptr_d = ckpt_ptr_q;
         since_d  = '0;
      end else if (ckpt_save) begin
         ckpt_ptr_d = rd_ptr_d;
         since_d    = '0;
      end
`endif
   end

   // State registers; reset refills the list with every non-architectural tag in ascending order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_TAGS; i++) begin
            mem_q[i] <= (i < INIT) ? TW'(RESERVED_TAGS + i) : '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= TW'(INIT);
         count_q  <= CW'(INIT);
         ovf_q    <= 1'b0;
`ifdef FREE_LIST_CKPT_EN
         ckpt_ptr_q <= '0;
         since_q    <= '0;
`endif
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
`ifdef FREE_LIST_CKPT_EN
         ckpt_ptr_q <= ckpt_ptr_d;
         since_q    <= since_d;
`endif
      end
   end

endmodule

// File: tb/tb_tag_free_list.sv
// Self-checking bench for tag_free_list against a queue-based model of the free tag pool.
// Latency: compares combinational outputs mid-cycle, registered state one cycle after each edge.
// Backpressure: model grants only when the request fits and drops overflowing free batches.
module tb_tag_free_list;

   localparam int N  = 128;
   localparam int R  = 32;
   localparam int TW = 7;

   logic          clk;
   logic          reset;
   logic [1:0]    alloc_num;
   logic          alloc_ready;
   logic [13:0]   alloc_tag;
   logic [1:0]    free_valid;
   logic [13:0]   free_tag;
   logic [7:0]    num_items;
   logic [7:0]    freespace;
   logic          overflow_err;
`ifdef FREE_LIST_CKPT_EN
   logic          ckpt_save;
   logic          ckpt_restore;
`endif

   int n_checks;
   int n_fail;

   // Reference model: the free pool as an ordered queue of tags.
   int q[$];
   int since[$];
   bit m_ovf;

   tag_free_list dut (
      .clk          (clk),
      .reset        (reset),
      .alloc_num    (alloc_num),
      .alloc_ready  (alloc_ready),
      .alloc_tag    (alloc_tag),
      .free_valid   (free_valid),
      .free_tag     (free_tag),
      .num_items    (num_items),
      .freespace    (freespace),
      .overflow_err (overflow_err)
`ifdef FREE_LIST_CKPT_EN
      ,
      .ckpt_save    (ckpt_save),
      .ckpt_restore (ckpt_restore)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      since.delete();
      for (int i = R; i < N; i++) q.push_back(i);
      m_ovf = 1'b0;
   endtask

   task automatic set_ckpt(input bit sv, input bit rs);
`ifdef FREE_LIST_CKPT_EN
      ckpt_save    = sv;
      ckpt_restore = rs;
`else
      if (sv || rs) $display("note: checkpoint request ignored in this build");
`endif
   endtask

   task automatic do_reset();
      alloc_num  = '0;
      free_valid = '0;
      free_tag   = '0;
      set_ckpt(1'b0, 1'b0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   // Registered-state view compared against the model at any point in the cycle.
   task automatic check_state(input string tag);
      check({tag, ".num_items"}, num_items, q.size());
      check({tag, ".freespace"}, freespace, N - q.size());
      check({tag, ".overflow_err"}, overflow_err, m_ovf);
   endtask

   // One clock: drive inputs, check outputs before the edge, then advance the model.
   task automatic cycle(input string tag, input int k, input logic [1:0] fv,
                        input int t0, input int t1, input bit sv, input bit rs);
      int   f;
      int   popped[$];
      bit   granted;
      alloc_num  = k[1:0];
      free_valid = fv;
      free_tag   = {t1[6:0], t0[6:0]};
      set_ckpt(sv, rs);
      #2;
      granted = !rs && (k <= q.size());
      check_state(tag);
      check({tag, ".alloc_ready"}, alloc_ready, granted);
      for (int i = 0; i < 2; i++) begin
         if (i < q.size()) check({tag, ".alloc_tag"}, alloc_tag[i*TW +: TW], q[i]);
      end
      @(posedge clk);
      #1;
      f = int'(fv[0]) + int'(fv[1]);
      if (rs) begin
         q = {since, q};
         since.delete();
      end else if (granted) begin
         for (int i = 0; i < k; i++) popped.push_back(q.pop_front());
         if (sv) since.delete();
         else    since = {since, popped};
      end else if (sv) begin
         since.delete();
      end
      if (q.size() + f > N) begin
         m_ovf = 1'b1;
      end else begin
         if (fv[0]) q.push_back(t0);
         if (fv[1]) q.push_back(t1);
      end
      alloc_num  = '0;
      free_valid = '0;
      set_ckpt(1'b0, 1'b0);
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      reset      = 1'b1;
      alloc_num  = '0;
      free_valid = '0;
      free_tag   = '0;
      set_ckpt(1'b0, 1'b0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset defaults.
      check("rst.num_items", num_items, 96);
      check("rst.freespace", freespace, 32);
      check("rst.alloc_tag", alloc_tag, {7'd33, 7'd32});
      check("rst.overflow_err", overflow_err, 0);

      // Drain the whole list two at a time; model supplies tags 32..127 in order.
      for (int c = 0; c < 48; c++) cycle("drain", 2, 2'b00, 0, 0, 0, 0);
      check("drain.empty", num_items, 0);
      cycle("empty_req", 1, 2'b00, 0, 0, 0, 0);

      // Free on port 1 while requesting on an empty list: no bypass.
      cycle("nobypass", 1, 2'b10, 0, 5, 0, 0);
      check("nobypass.ready", alloc_ready, 1);
      check("nobypass.tag0", alloc_tag[6:0], 5);
      cycle("nobypass_take", 1, 2'b00, 0, 0, 0, 0);

      // Wrap: push 100 tags one per cycle across index 127->0, then drain in FIFO order.
      for (int c = 0; c < 100; c++) cycle("wrap_fill", 0, 2'b01, (c * 37 + 3) % N, 0, 0, 0);
      for (int c = 0; c < 50; c++) cycle("wrap_drain", 2, 2'b00, 0, 0, 0, 0);
      check("wrap.empty", num_items, 0);

      // Overflow: fill to 128, one more free is dropped and the error sticks until reset.
      do_reset();
      for (int c = 0; c < 16; c++) cycle("fill", 0, 2'b11, c, c + 16, 0, 0);
      check("full.num_items", num_items, 128);
      cycle("ovf", 0, 2'b01, 9, 0, 0, 0);
      check("ovf.flag", overflow_err, 1);
      check("ovf.num_items", num_items, 128);
      cycle("ovf_hold", 1, 2'b00, 0, 0, 0, 0);
      cycle("ovf_hold2", 0, 2'b00, 0, 0, 0, 0);
      check("ovf.sticky", overflow_err, 1);
      do_reset();
      check("ovf.cleared", overflow_err, 0);

`ifdef FREE_LIST_CKPT_EN
      // Checkpoint at 96, allocate 6, free 2, restore.
      cycle("ck_save", 0, 2'b00, 0, 0, 1, 0);
      for (int c = 0; c < 3; c++) cycle("ck_alloc", 2, 2'b00, 0, 0, 0, 0);
      cycle("ck_free", 0, 2'b11, 40, 41, 0, 0);
      cycle("ck_restore", 1, 2'b00, 0, 0, 0, 1);
      check("ck.num_items", num_items, 98);
      check("ck.tag0", alloc_tag[6:0], 32);
      do_reset();
`endif

      // Random traffic; frees are limited so restored slots are never overwritten.
      for (int c = 0; c < 600; c++) begin
         int          k;
         logic [1:0]  fv;
         bit          sv;
         bit          rs;
         int          f;
         k  = $urandom_range(0, 2);
         fv = 2'($urandom_range(0, 3));
         f  = int'(fv[0]) + int'(fv[1]);
         if (q.size() + since.size() + f > N) fv = 2'b00;
         sv = 1'b0;
         rs = 1'b0;
`ifdef FREE_LIST_CKPT_EN
         sv = ($urandom_range(0, 15) == 0);
         rs = ($urandom_range(0, 19) == 0);
`endif
         cycle("rand", k, fv, $urandom_range(0, N - 1), $urandom_range(0, N - 1), sv, rs);
      end
      check_state("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
